// File: rtl/sdram_port_arbiter.sv
// Two-port arbiter in front of an SDRAM controller core: picks a requester,
// issues one read/write command enable per transfer and supervises core_busy.
//
// state      | meaning
// IDLE       | no owner; waiting for sdram_ready and a request
// ISSUE      | grant given; raise the command enable from the latched direction
// WAIT_START | enable high; waiting for core_busy to rise
// ACTIVE     | core working; enable held while the owner keeps requesting
// DRAIN      | enable dropped; waiting for core_busy to fall
// DONE       | one-cycle done/error pulse to the owner, then release grant
module sdram_port_arbiter #(
  parameter int ADDR_WIDTH    = 22,
  parameter int START_TIMEOUT = 16,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  b_req,
  input  logic                  a_write,
  input  logic                  b_write,
  input  logic [ADDR_WIDTH-1:0] a_address,
  input  logic [ADDR_WIDTH-1:0] b_address,
  output logic                  a_grant,
  output logic                  b_grant,
  output logic                  a_done,
  output logic                  b_done,
  output logic                  a_error,
  output logic                  b_error,
  input  logic                  sdram_ready,
  input  logic                  core_busy,
  output logic                  sdram_write_enable,
  output logic                  sdram_read_enable,
  output logic [ADDR_WIDTH-1:0] app_address,
  output logic                  active_port
);

  localparam int CNT_MAX = (START_TIMEOUT > DRAIN_TIMEOUT) ? START_TIMEOUT : DRAIN_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] START_LD = CW'(START_TIMEOUT);
  localparam logic [CW-1:0] DRAIN_LD = CW'(DRAIN_TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_START, ACTIVE, DRAIN, DONE
  } state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  port, port_n;
  logic                  write_lat, write_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic                  granted, granted_n;
  logic                  wr_en, wr_en_n;
  logic                  rd_en, rd_en_n;
  logic                  done_q, done_n;
  logic                  err_q, err_n;
  logic                  err_flag, err_flag_n;
  logic                  last_port, last_n;
  logic [1:0]            sync_q;
  logic                  run;
  logic                  req_g;
  logic                  sel;
  logic                  abort;

  // Reset release is re-timed so the FSM never acts on a partially released reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], 1'b1};
  end
  assign run = sync_q[1];

  assign req_g = port ? b_req : a_req;
  // Losing the core mid-transfer aborts; DONE is already releasing the port.
  assign abort = !sdram_ready && (state != IDLE) && (state != DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      port      <= 1'b0;
      write_lat <= 1'b0;
      addr      <= '0;
      granted   <= 1'b0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_flag  <= 1'b0;
      last_port <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      port      <= port_n;
      write_lat <= write_n;
      addr      <= addr_n;
      granted   <= granted_n;
      wr_en     <= wr_en_n;
      rd_en     <= rd_en_n;
      done_q    <= done_n;
      err_q     <= err_n;
      err_flag  <= err_flag_n;
      last_port <= last_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    port_n     = port;
    write_n    = write_lat;
    addr_n     = addr;
    granted_n  = granted;
    wr_en_n    = wr_en;
    rd_en_n    = rd_en;
    done_n     = 1'b0;
    err_n      = 1'b0;
    err_flag_n = err_flag;
    last_n     = last_port;
    sel        = 1'b0;

    case (state)
      IDLE: begin
        if (run && sdram_ready && (a_req || b_req)) begin
          sel       = (a_req && b_req) ? ~last_port : b_req;
          port_n    = sel;
          write_n   = sel ? b_write : a_write;
          addr_n    = sel ? b_address : a_address;
          granted_n = 1'b1;
          state_n   = ISSUE;
        end
      end
      ISSUE: begin
        wr_en_n = write_lat;
        rd_en_n = ~write_lat;
        cnt_n   = START_LD;
        state_n = WAIT_START;
      end
      WAIT_START: begin
        if (core_busy) begin
          state_n = ACTIVE;
        end else if (!req_g) begin
          wr_en_n = 1'b0;
          rd_en_n = 1'b0;
          cnt_n   = DRAIN_LD;
          state_n = DRAIN;
        end else if (cnt <= CNT_ONE) begin
          wr_en_n    = 1'b0;
          rd_en_n    = 1'b0;
          err_flag_n = 1'b1;
          cnt_n      = '0;
          done_n     = 1'b1;
          err_n      = 1'b1;
          state_n    = DONE;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      ACTIVE: begin
        if (!req_g) begin
          wr_en_n = 1'b0;
          rd_en_n = 1'b0;
          cnt_n   = DRAIN_LD;
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (!core_busy) begin
          cnt_n   = '0;
          done_n  = 1'b1;
          err_n   = err_flag;
          state_n = DONE;
        end else if (cnt <= CNT_ONE) begin
          err_flag_n = 1'b1;
          cnt_n      = '0;
          done_n     = 1'b1;
          err_n      = 1'b1;
          state_n    = DONE;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      DONE: begin
        granted_n  = 1'b0;
        last_n     = port;
        err_flag_n = 1'b0;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (abort) begin
      state_n    = IDLE;
      granted_n  = 1'b0;
      wr_en_n    = 1'b0;
      rd_en_n    = 1'b0;
      cnt_n      = '0;
      done_n     = 1'b1;
      err_n      = 1'b1;
      err_flag_n = 1'b0;
      last_n     = port;
    end
  end

  assign a_grant            = granted & ~port;
  assign b_grant            = granted & port;
  assign a_done             = done_q & ~port;
  assign b_done             = done_q & port;
  assign a_error            = err_q & ~port;
  assign b_error            = err_q & port;
  assign sdram_write_enable = wr_en;
  assign sdram_read_enable  = rd_en;
  assign app_address        = addr;
  assign active_port        = port;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: per-cycle vector table plus
// hand-written sequences for timeouts, core loss, async reset and fairness.
module tb_sdram_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_req, b_req, a_write, b_write;
  logic [21:0] a_address, b_address;
  logic        a_grant, b_grant, a_done, b_done, a_error, b_error;
  logic        sdram_ready, core_busy;
  logic        sdram_write_enable, sdram_read_enable;
  logic [21:0] app_address;
  logic        active_port;

  int total = 0;
  int bad   = 0;

  sdram_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .b_req(b_req), .a_write(a_write), .b_write(b_write),
    .a_address(a_address), .b_address(b_address),
    .a_grant(a_grant), .b_grant(b_grant), .a_done(a_done), .b_done(b_done),
    .a_error(a_error), .b_error(b_error),
    .sdram_ready(sdram_ready), .core_busy(core_busy),
    .sdram_write_enable(sdram_write_enable), .sdram_read_enable(sdram_read_enable),
    .app_address(app_address), .active_port(active_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        a_req, b_req, a_write, b_write;
    logic [21:0] a_addr, b_addr;
    logic        ready, busy;
    logic [8:0]  exp_flags;  // {a_grant,b_grant,wr,rd,a_done,b_done,a_err,b_err,active_port}
    logic [21:0] exp_addr;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] flags();
    return {a_grant, b_grant, sdram_write_enable, sdram_read_enable,
            a_done, b_done, a_error, b_error, active_port};
  endfunction

  initial begin
    int n;
    int guard;
    logic ok;

    vecs[0]  = '{0,1,0,0, 22'h0,      22'h0AAAA,  1,0, 9'b0_1_0_0_0_0_0_0_1, 22'h0AAAA};
    vecs[1]  = '{1,1,1,1, 22'h123,    22'h3FFFFF, 1,0, 9'b0_1_0_1_0_0_0_0_1, 22'h0AAAA};
    vecs[2]  = '{1,1,1,1, 22'h123,    22'h3FFFFF, 1,1, 9'b0_1_0_1_0_0_0_0_1, 22'h0AAAA};
    vecs[3]  = '{1,1,1,1, 22'h123,    22'h3FFFFF, 1,1, 9'b0_1_0_1_0_0_0_0_1, 22'h0AAAA};
    vecs[4]  = '{1,0,1,1, 22'h123,    22'h3FFFFF, 1,1, 9'b0_1_0_0_0_0_0_0_1, 22'h0AAAA};
    vecs[5]  = '{1,0,1,1, 22'h123,    22'h3FFFFF, 1,1, 9'b0_1_0_0_0_0_0_0_1, 22'h0AAAA};
    vecs[6]  = '{1,0,1,1, 22'h123,    22'h3FFFFF, 1,0, 9'b0_1_0_0_0_1_0_0_1, 22'h0AAAA};
    vecs[7]  = '{1,0,1,1, 22'h123,    22'h3FFFFF, 1,0, 9'b0_0_0_0_0_0_0_0_1, 22'h0AAAA};
    vecs[8]  = '{1,0,1,0, 22'h123,    22'h0,      1,0, 9'b1_0_0_0_0_0_0_0_0, 22'h123};
    vecs[9]  = '{1,0,0,0, 22'h3FFFFF, 22'h0,      1,0, 9'b1_0_1_0_0_0_0_0_0, 22'h123};
    vecs[10] = '{0,0,0,0, 22'h3FFFFF, 22'h0,      1,0, 9'b1_0_0_0_0_0_0_0_0, 22'h123};
    vecs[11] = '{0,0,0,0, 22'h3FFFFF, 22'h0,      1,0, 9'b1_0_0_0_1_0_0_0_0, 22'h123};
    vecs[12] = '{0,0,0,0, 22'h3FFFFF, 22'h0,      1,0, 9'b0_0_0_0_0_0_0_0_0, 22'h123};

    rst_n = 1'b0; a_req = 0; b_req = 0; a_write = 0; b_write = 0;
    a_address = '0; b_address = '0; sdram_ready = 1'b1; core_busy = 1'b0;
    #2;
    check("reset_flags", 32'(flags()), 32'h0);
    check("reset_addr", 32'(app_address), 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();

    // per-cycle vector table: B read with mid-transfer input changes, then A write
    for (int i = 0; i < 13; i++) begin
      a_req = vecs[i].a_req; b_req = vecs[i].b_req;
      a_write = vecs[i].a_write; b_write = vecs[i].b_write;
      a_address = vecs[i].a_addr; b_address = vecs[i].b_addr;
      sdram_ready = vecs[i].ready; core_busy = vecs[i].busy;
      tick();
      check($sformatf("vec%0d_flags", i), 32'(flags()), 32'(vecs[i].exp_flags));
      check($sformatf("vec%0d_addr", i), 32'(app_address), 32'(vecs[i].exp_addr));
    end

    // single write with core_busy handshake
    a_req = 1; a_write = 1; a_address = 22'h000100; core_busy = 0;
    tick();
    check("wr_grant_t1", 32'({a_grant, b_grant, sdram_write_enable}), 32'b100);
    tick();
    check("wr_en_t2", 32'({sdram_write_enable, sdram_read_enable}), 32'b10);
    check("wr_addr_t2", 32'(app_address), 32'h100);
    a_address = 22'h2AAAAA; a_write = 0;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); if (!sdram_write_enable) ok = 1'b0; end
    core_busy = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!sdram_write_enable || app_address != 22'h100 || !a_grant) ok = 1'b0;
    end
    check("wr_enable_held", 32'(ok), 32'h1);
    a_req = 0;
    tick();
    check("wr_en_drop", 32'({a_grant, sdram_write_enable, a_done}), 32'b100);
    tick();
    core_busy = 0;
    tick();
    check("wr_done", 32'({a_grant, a_done, a_error}), 32'b110);
    tick();
    check("wr_release", 32'({a_grant, b_grant, a_done}), 32'b000);

    // start timeout on port B read
    b_req = 1; b_write = 0; core_busy = 0;
    tick(); tick();
    n = 0;
    while (sdram_read_enable && n < 100) begin n++; tick(); end
    check("st_en_cycles", 32'(n), 32'd16);
    check("st_done_err", 32'({b_grant, b_done, b_error, sdram_read_enable}), 32'b1110);
    b_req = 0;
    tick();
    check("st_release", 32'({b_grant, b_done, b_error}), 32'b000);

    // drain timeout on port A with core_busy stuck high
    a_req = 1; a_write = 0; core_busy = 1;
    tick(); tick(); tick();
    a_req = 0;
    tick();
    check("dr_en_low", 32'({a_grant, sdram_read_enable}), 32'b10);
    n = 0;
    while (!a_done && n < 5000) begin tick(); n++; end
    check("dr_cycles", 32'(n), 32'd4096);
    check("dr_err", 32'({a_done, a_error}), 32'b11);
    core_busy = 0;
    tick();
    check("dr_release", 32'(a_grant), 32'h0);

    // core loss during ACTIVE
    b_req = 1; b_write = 1; core_busy = 1;
    tick(); tick(); tick();
    check("cl_active", 32'({b_grant, sdram_write_enable}), 32'b11);
    sdram_ready = 0;
    tick();
    check("cl_abort", 32'({a_grant, b_grant, sdram_write_enable, sdram_read_enable, b_done, b_error}),
          32'b000011);
    a_req = 1;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin tick(); if (a_grant || b_grant) ok = 1'b0; end
    check("cl_no_grant", 32'(ok), 32'h1);
    a_req = 0; b_req = 0; core_busy = 0; sdram_ready = 1;
    tick();

    // async reset mid-transfer
    a_req = 1; a_write = 1; core_busy = 1;
    tick(); tick(); tick();
    check("ar_pre", 32'({a_grant, sdram_write_enable}), 32'b11);
    #3 rst_n = 1'b0;
    #1;
    check("ar_flags", 32'(flags()), 32'h0);
    check("ar_addr", 32'(app_address), 32'h0);

    // tie and fairness straight out of reset, busy never rises
    b_req = 1; core_busy = 0;
    tick(); tick();
    rst_n = 1'b1;
    begin
      int order[3];
      int ng, gap, overlap, gaps_bad, cyc;
      logic prev_any, any;
      ng = 0; gap = 0; overlap = 0; gaps_bad = 0; cyc = 0; prev_any = 1'b0;
      order[0] = -1; order[1] = -1; order[2] = -1;
      while (ng < 3 && cyc < 300) begin
        tick(); cyc++;
        any = a_grant | b_grant;
        if (a_grant && b_grant) overlap++;
        if (any && !prev_any) begin
          if (ng > 0 && gap != 1) gaps_bad++;
          order[ng] = int'(b_grant);
          ng++;
        end
        if (!any) gap++; else gap = 0;
        prev_any = any;
      end
      check("tie_count", 32'(ng), 32'd3);
      check("tie_first_a", 32'(order[0]), 32'd0);
      check("tie_second_b", 32'(order[1]), 32'd1);
      check("tie_third_a", 32'(order[2]), 32'd0);
      check("tie_overlap", 32'(overlap), 32'd0);
      check("tie_idle_gap", 32'(gaps_bad), 32'd0);
    end
    a_req = 0; b_req = 0;
    guard = 0;
    while ((a_grant || b_grant) && guard < 50) begin tick(); guard++; end
    check("final_idle", 32'({a_grant, b_grant}), 32'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
